// File: rtl/ifq_32.sv
// ifq_32: instruction fetch queue.
// A fetch FSM issues word reads to instruction memory. Each response is
// pushed into a small FIFO together with its own address, and IF/ID pops
// the FIFO. A credit rule, count + inflight < DEPTH, keeps the queue from
// overflowing.
// Optional feature: define IFQ_HLT_STOP_EN to make a fetched HLT word
// (opcode 6'b111111) park the FSM in STOP. Without it, STOP is unreachable
// and stopped is tied to 0.
module ifq_32 #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [9:0]  RESET_PC = 10'd0
) (
  input  logic        clk1,
  input  logic        rst,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [9:0]  redirect_pc,
  input  logic        hold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ir_out,
  output logic [31:0] npc_out,
  output logic        stopped
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {FETCH, STOP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        word_q [DEPTH];
  logic [9:0]         addr_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               inflight;
  logic [9:0]         inflight_addr;
  logic [9:0]         fetch_pc;
  logic               push;
  logic               pop;
  logic               credit_ok;

  // Redirect discards the inflight response and overrides any pop.
  assign push      = inflight & !redirect;
  assign pop       = out_valid & out_ready & !redirect;
  assign credit_ok = (32'(count) + 32'(inflight)) < 32'(DEPTH);

  assign out_valid = (count != '0);
  assign imem_addr = fetch_pc;
  assign ir_out    = out_valid ? word_q[rd_ptr] : 32'd0;
  assign npc_out   = out_valid ? (32'(addr_q[rd_ptr]) + 32'd1) : 32'd0;

`ifdef IFQ_HLT_STOP_EN
  logic is_hlt;
  assign is_hlt  = (imem_rdata[31:26] == 6'b111111);
  assign stopped = (state == STOP);
`else
  assign stopped = 1'b0;
`endif

  // Fetch FSM state register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next state and request issue; redirect and reset override everything.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = !hold & !redirect & credit_ok;
`ifdef IFQ_HLT_STOP_EN
        // An HLT word being pushed stops fetch this very cycle.
        if (push && is_hlt) begin
          state_nxt = STOP;
          imem_req  = 1'b0;
        end
`endif
      end
      STOP:    imem_req = 1'b0;
      default: state_nxt = FETCH;
    endcase
    if (redirect) state_nxt = FETCH;
    if (rst)      imem_req  = 1'b0;
  end

  // Fetch PC, inflight tracking, and queue pointers/occupancy.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= 10'd0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_addr <= fetch_pc;
        fetch_pc      <= fetch_pc + 10'd1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage. Occupancy is tracked by count, so the storage needs no reset.
  always_ff @(posedge clk1) begin
    if (push) begin
      word_q[wr_ptr] <= imem_rdata;
      addr_q[wr_ptr] <= inflight_addr;
    end
  end

endmodule

// File: tb/tb_ifq_32.sv
// tb_ifq_32: directed bench for ifq_32, with a main instance (RESET_PC=0)
// and a second instance (RESET_PC=1022) for address wraparound.
module tb_ifq_32;

  logic        clk1;
  logic        rst;
  logic        hold;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        out_ready;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] ir_out;
  logic [31:0] npc_out;
  logic        stopped;

  logic        w_req;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_ir;
  logic [31:0] w_npc;
  logic        w_stopped;
  logic        w_ready;
  logic        w_zero;
  logic [9:0]  w_zero_pc;

  logic [31:0] mem [1024];
  logic [31:0] w_ir_exp  [3];
  logic [31:0] w_npc_exp [3];
  int          n_checks;
  int          n_err;

  ifq_32 #(.DEPTH(4), .RESET_PC(10'd0)) u_dut (
    .clk1(clk1), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .hold(hold), .out_valid(out_valid), .out_ready(out_ready),
    .ir_out(ir_out), .npc_out(npc_out), .stopped(stopped)
  );

  ifq_32 #(.DEPTH(4), .RESET_PC(10'd1022)) u_wrap (
    .clk1(clk1), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect(w_zero), .redirect_pc(w_zero_pc),
    .hold(w_zero), .out_valid(w_valid), .out_ready(w_ready),
    .ir_out(w_ir), .npc_out(w_npc), .stopped(w_stopped)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Instruction memory models: data returned one cycle after the request.
  always @(posedge clk1) if (imem_req) imem_rdata <= mem[imem_addr];
  always @(posedge clk1) if (w_req)    w_rdata    <= mem[w_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 10'd0;
    out_ready = 1'b1; w_ready = 1'b1; w_zero = 1'b0; w_zero_pc = 10'd0;
    imem_rdata = 32'd0; w_rdata = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    w_ir_exp[0]  = 32'd1022; w_ir_exp[1]  = 32'd1023; w_ir_exp[2]  = 32'd0;
    w_npc_exp[0] = 32'd1023; w_npc_exp[1] = 32'd1024; w_npc_exp[2] = 32'd1;

    // Reset state
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check("rst_req",     32'(imem_req),  32'd0);
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_ir",      ir_out,         32'd0);
    check("rst_npc",     npc_out,        32'd0);
    check("rst_stopped", 32'(stopped),   32'd0);
    check("rst_w_req",   32'(w_req),     32'd0);

    // Cycle 0: first request
    step(); rst = 1'b0;
    @(negedge clk1);
    check("c0_req",    32'(imem_req),  32'd1);
    check("c0_addr",   32'(imem_addr), 32'd0);
    check("c0_valid",  32'(out_valid), 32'd0);
    check("c0_w_addr", 32'(w_addr),    32'd1022);
    // Cycle 1: response in flight, queue still empty
    step();
    @(negedge clk1);
    check("c1_valid",  32'(out_valid), 32'd0);
    check("c1_addr",   32'(imem_addr), 32'd1);
    check("c1_w_addr", 32'(w_addr),    32'd1023);
    // Cycles 2..7: one instruction per cycle
    for (int k = 2; k <= 7; k++) begin
      step();
      @(negedge clk1);
      check("fill_valid", 32'(out_valid), 32'd1);
      check("fill_ir",    ir_out,         32'(k - 2));
      check("fill_npc",   npc_out,        32'(k - 1));
      if (k == 2) check("wrap_addr", 32'(w_addr), 32'd0);
      if (k <= 4) begin
        check("wrap_ir",  w_ir,  w_ir_exp[k-2]);
        check("wrap_npc", w_npc, w_npc_exp[k-2]);
      end
    end

    // Backpressure for 10 cycles (8..17): queue fills to DEPTH and stalls
    for (int k = 8; k <= 17; k++) begin
      step();
      if (k == 8) out_ready = 1'b0;
    end
    @(negedge clk1);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_req",   32'(imem_req),  32'd0);
    check("full_ir",    ir_out,         32'd6);
    // Drain (18..23): strictly in order, no loss
    for (int k = 18; k <= 23; k++) begin
      step();
      if (k == 18) out_ready = 1'b1;
      @(negedge clk1);
      if (k == 18) check("drain_req", 32'(imem_req), 32'd0);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_ir",    ir_out,         32'(k - 12));
    end

    // Cycle 24: build three entries plus an inflight request
    step(); out_ready = 1'b0;
    @(negedge clk1);
    check("c24_ir",   ir_out,         32'd12);
    check("c24_addr", 32'(imem_addr), 32'd15);
    // Cycle 25: redirect to 100 with a pop attempt
    step(); redirect = 1'b1; redirect_pc = 10'd100; out_ready = 1'b1;
    @(negedge clk1);
    check("redir_req", 32'(imem_req), 32'd0);
    step(); redirect = 1'b0;
    @(negedge clk1);
    check("redir_valid0", 32'(out_valid), 32'd0);
    check("redir_req1",   32'(imem_req),  32'd1);
    check("redir_addr",   32'(imem_addr), 32'd100);
    step();
    @(negedge clk1);
    check("redir_valid1", 32'(out_valid), 32'd0);
    step();
    @(negedge clk1);
    check("redir_ir",  ir_out,  32'd100);
    check("redir_npc", npc_out, 32'd101);

    // Hold: no requests, but the inflight push and pops still happen
    step(); hold = 1'b1;
    @(negedge clk1);
    check("hold_req", 32'(imem_req), 32'd0);
    check("hold_ir0", ir_out,        32'd101);
    step();
    @(negedge clk1);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_ir1",   ir_out,         32'd102);
    step(); hold = 1'b0;
    @(negedge clk1);
    check("unhold_valid", 32'(out_valid), 32'd0);
    check("unhold_addr",  32'(imem_addr), 32'd103);

    // HLT word at address 5, restart fetch from 0 (cycle 32)
    mem[5] = 32'hFC000000;
    step(); redirect = 1'b1; redirect_pc = 10'd0;
    @(negedge clk1);
    check("hlt_redir_req", 32'(imem_req), 32'd0);
    step(); redirect = 1'b0;
    @(negedge clk1);
    check("hlt_addr0", 32'(imem_addr), 32'd0);
    for (int k = 34; k <= 41; k++) begin
      step();
      @(negedge clk1);
      if (k >= 35 && k <= 39) check("hlt_ir", ir_out, 32'(k - 35));
      if (k == 40) begin
        check("hlt_ir5",  ir_out,  32'hFC000000);
        check("hlt_npc5", npc_out, 32'd6);
      end
`ifdef IFQ_HLT_STOP_EN
      if (k == 39) check("hlt_req_blocked", 32'(imem_req),  32'd0);
      if (k == 40) check("hlt_stopped",     32'(stopped),   32'd1);
      if (k == 41) check("hlt_drained",     32'(out_valid), 32'd0);
`else
      if (k == 39) check("hlt_addr6",   32'(imem_addr), 32'd6);
      if (k == 40) check("hlt_running", 32'(stopped),   32'd0);
      if (k == 41) check("hlt_ir6",     ir_out,         32'd6);
`endif
    end
    step(); redirect = 1'b1; redirect_pc = 10'd0;
    @(negedge clk1);
`ifdef IFQ_HLT_STOP_EN
    check("stop_hold", 32'(stopped), 32'd1);
`else
    check("stop_hold", 32'(stopped), 32'd0);
`endif
    step(); redirect = 1'b0;
    @(negedge clk1);
    check("restart_stopped", 32'(stopped),   32'd0);
    check("restart_req",     32'(imem_req),  32'd1);
    check("restart_addr",    32'(imem_addr), 32'd0);

    // Reset mid-stream while a request is outstanding
    step(); rst = 1'b1;
    @(negedge clk1);
    check("mrst_req",     32'(imem_req),  32'd0);
    check("mrst_addr",    32'(imem_addr), 32'd0);
    check("mrst_valid",   32'(out_valid), 32'd0);
    check("mrst_ir",      ir_out,         32'd0);
    check("mrst_npc",     npc_out,        32'd0);
    check("mrst_stopped", 32'(stopped),   32'd0);
    step(); rst = 1'b0;
    @(negedge clk1);
    check("post_req",  32'(imem_req),  32'd1);
    check("post_addr", 32'(imem_addr), 32'd0);
    step();
    @(negedge clk1);
    check("post_valid0", 32'(out_valid), 32'd0);
    step();
    @(negedge clk1);
    check("post_valid", 32'(out_valid), 32'd1);
    check("post_ir",    ir_out,         32'd0);
    check("post_npc",   npc_out,        32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
